lsu_trigger_ctl: RTL and testbench
==================================

Name: lsu_trigger_ctl

Overview:
Owns the four LSU debug-trigger slots. Holds the tdata1/tdata2 state per slot, drives the trigger_pkt_any packets consumed by the LSU address/data match logic, and registers the per-slot dc3 match results into dc4. It evaluates chaining (0→1, 2→3), sets sticky hit bits, and runs a request/ack handshake to the decode unit for the breakpoint-exception or debug-entry action.

Parameters:
NUM_TRIG, 4, trigger slots; fixed at 4, chaining pairs are hard-wired (0,1) and (2,3)
TYPE_VAL, 2, value returned in tdata1[31:28] (mcontrol)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
dbg_mode  in  1  core is in debug mode
csr_wr_valid  in  1  CSR write request
csr_wr_ready  out  1  write accepted when valid&ready
csr_wr_idx  in  2  slot select
csr_wr_reg  in  1  0=tdata1, 1=tdata2
csr_wr_data  in  32  write data
csr_rd_idx  in  2  read slot select
csr_rd_reg  in  2  0=tdata1, 1=tdata2, 2=hit count (feature only)
csr_rd_data  out  32  combinational read data
trigger_pkt_any  out  4 x trigger_pkt_t  packets to LSU match logic (select, match, store, load, tdata2 used)
lsu_trigger_match_dc3  in  4  raw per-slot match from LSU
lsu_kill_dc3  in  1  dc3 instruction flushed; discard its matches
trig_req_valid  out  1  action request to decode
trig_req_action  out  1  0=breakpoint exception, 1=enter debug
trig_req_vec  out  4  slots that fired
trig_req_ack  in  1  decode accepts request

Behaviour:
- tdata1 stored fields: dmode[27], hit[20], select[19], action[12], chain[11], match[7], m[6], store[1], load[0]. Others read 0; [31:28]=TYPE_VAL. chain reads 0 on slots 1,3.
- Reset: all tdata1/tdata2 = 0, FSM=IDLE, trig_req_valid=0, trig_req_vec=0, trig_req_action=0, dc4 match reg=0, csr_wr_ready=1.
- Write rules: csr_wr_ready = (state==IDLE). Write to a slot with dmode=1 while dbg_mode=0 is accepted but ignored. Writing dmode requires dbg_mode=1; otherwise the bit stays 0. A write takes effect the next cycle.
- Packet: select, match, store, tdata2 from regs. load = load & ~select. store/load are forced to 0 when m=0 or dbg_mode=1 (no triggers in debug mode).
- Pipeline: match_dc4 <= lsu_trigger_match_dc3 & ~{4{lsu_kill_dc3}}. Registered every cycle, 1-cycle latency.
- Chain: fire[0] = m0 & (~chain0 | m1); fire[1] = m1 & (~chain0 | m0); same for 2/3 with chain2. A chained pair fires only when both slots match in the same dc4 cycle.
- FSM IDLE: if |fire, then hit bit of each fired slot <= 1, trig_req_vec <= fire, and trig_req_action <= OR of action over fired slots (debug wins). Go to REQ.
- FSM REQ: trig_req_valid=1 and outputs held stable. On trig_req_ack → IDLE; trig_req_valid drops the following cycle. New fires in REQ are dropped and do not set hit bits.
- Simultaneous CSR write to a tdata1 and hit-set on the same slot: the write wins. Hit is only cleared by a CSR write.
- Reset mid-REQ: immediate return to IDLE, with no request output on the next cycle.

Optional Feature:
LSU_TRIG_HITCNT_EN
- Defined: each slot has a 16-bit saturating counter, incremented by 1 on every fire accepted in IDLE (saturates at 0xFFFF). Read via csr_rd_reg=2 as {16'b0,cnt}. Cleared by reset or by any tdata1 write to that slot.
- Undefined: no counters; csr_rd_reg=2 reads 0.

Test Plan:
- Store trigger: slot0 tdata1=0x0000_0042 (m, store), tdata2=0x1000; match0 pulse → 1 cycle later trig_req_valid=1, vec=4'b0001, action=0; tdata1 reads 0x2010_0042. Ack → valid=0 next cycle.
- Chain: slot2 chain=1 with slot3 enabled; match2 alone → no request. match2&match3 same cycle → vec=4'b1100.
- Kill: match1 with lsu_kill_dc3=1 → no request and hit stays 0.
- Busy: in REQ, csr_wr_ready=0 and a second match on slot1 is dropped (hit1=0 after ack). Mixed action: slots 0 (action 0) and 1 (action 1) fire together → action=1.
- dmode lock: with dbg_mode=1, write slot0 tdata1 with dmode=1; with dbg_mode=0, write 0 → readback unchanged. In dbg_mode=1, packet load/store=0.
- Feature on: 3 accepted fires on slot0 → csr_rd_reg=2 reads 3. tdata1 write → reads 0.

Source files
------------

// File: rtl/lsu_trigger_ctl.sv
// LSU debug-trigger slots: tdata1/tdata2 state, match packets, dc4 chaining and decode request handshake.
// Optional per-slot 16-bit hit counters are built when LSU_TRIG_HITCNT_EN is defined.
package lsu_trigger_ctl_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            select;
    logic            match;
    logic            store;
    logic            load;
    logic [XLEN-1:0] tdata2;
  } trigger_pkt_t;
endpackage

module lsu_trigger_ctl
  import lsu_trigger_ctl_pkg::*;
#(
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned TYPE_VAL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dbg_mode,
  input  logic                          csr_wr_valid,
  output logic                          csr_wr_ready,
  input  logic [1:0]                    csr_wr_idx,
  input  logic                          csr_wr_reg,
  input  logic [31:0]                   csr_wr_data,
  input  logic [1:0]                    csr_rd_idx,
  input  logic [1:0]                    csr_rd_reg,
  output logic [31:0]                   csr_rd_data,
  output trigger_pkt_t [NUM_TRIG-1:0]   trigger_pkt_any,
  input  logic [NUM_TRIG-1:0]           lsu_trigger_match_dc3,
  input  logic                          lsu_kill_dc3,
  output logic                          trig_req_valid,
  output logic                          trig_req_action,
  output logic [NUM_TRIG-1:0]           trig_req_vec,
  input  logic                          trig_req_ack
);

  localparam int unsigned DMODE  = 27;
  localparam int unsigned HIT    = 20;
  localparam int unsigned SELECT = 19;
  localparam int unsigned ACTION = 12;
  localparam int unsigned CHAIN  = 11;
  localparam int unsigned MATCH  = 7;
  localparam int unsigned MBIT   = 6;
  localparam int unsigned STORE  = 1;
  localparam int unsigned LOAD   = 0;
  localparam int unsigned T1W    = 28;
  localparam logic [T1W-1:0] T1_WMASK = 28'h818_18C3;

  typedef enum logic {IDLE, REQ} state_e;

  state_e                state_q, state_d;
  logic [NUM_TRIG-1:0]   vec_q, vec_d;
  logic                  action_q, action_d;
  logic [NUM_TRIG-1:0]   match_dc4_q;
  logic [T1W-1:0]        t1_q [NUM_TRIG];
  logic [31:0]           t2_q [NUM_TRIG];

  logic [NUM_TRIG-1:0]   fire, act_vec, hit_set, wr_t1, wr_t2;
  logic                  wr_en;
  logic [T1W-1:0]        wr_val;
  logic                  unused_wr_hi;

  assign unused_wr_hi   = ^csr_wr_data[31:T1W];
  assign csr_wr_ready   = (state_q == IDLE);
  assign trig_req_valid = (state_q == REQ);
  assign trig_req_vec   = vec_q;
  assign trig_req_action = action_q;

  // Write decode: dmode-owned slots are frozen outside debug mode, dmode itself needs debug mode
  always_comb begin
    wr_t1  = '0;
    wr_t2  = '0;
    wr_en  = csr_wr_valid & csr_wr_ready & ~(t1_q[csr_wr_idx][DMODE] & ~dbg_mode);
    wr_t1[csr_wr_idx] = wr_en & ~csr_wr_reg;
    wr_t2[csr_wr_idx] = wr_en & csr_wr_reg;
    wr_val = csr_wr_data[T1W-1:0] & T1_WMASK;
    if (!dbg_mode)     wr_val[DMODE] = 1'b0;
    if (csr_wr_idx[0]) wr_val[CHAIN] = 1'b0;
  end

  // Chained pairs fire only when both members match in the same dc4 cycle
  always_comb begin
    fire = match_dc4_q;
    if (t1_q[0][CHAIN]) fire[1:0] = {2{&match_dc4_q[1:0]}};
    if (t1_q[2][CHAIN]) fire[3:2] = {2{&match_dc4_q[3:2]}};
    for (int i = 0; i < NUM_TRIG; i++) act_vec[i] = t1_q[i][ACTION];
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    action_d = action_q;
    hit_set  = '0;
    case (state_q)
      IDLE: begin
        if (|fire) begin
          hit_set  = fire;
          vec_d    = fire;
          action_d = |(fire & act_vec);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (trig_req_ack) begin
          vec_d    = '0;
          action_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      action_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      action_q <= action_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_dc4_q <= '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
        t1_q[i] <= '0;
        t2_q[i] <= '0;
      end
    end else begin
      match_dc4_q <= lsu_trigger_match_dc3 & ~{NUM_TRIG{lsu_kill_dc3}};
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr_t1[i])        t1_q[i]      <= wr_val;
        else if (hit_set[i]) t1_q[i][HIT] <= 1'b1;
        if (wr_t2[i])        t2_q[i]      <= csr_wr_data;
      end
    end
  end

`ifdef LSU_TRIG_HITCNT_EN
  logic [15:0] cnt_q [NUM_TRIG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRIG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr_t1[i])                             cnt_q[i] <= '0;
        else if (hit_set[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    csr_rd_data = '0;
    case (csr_rd_reg)
      2'd0:    csr_rd_data = {4'(TYPE_VAL), t1_q[csr_rd_idx]};
      2'd1:    csr_rd_data = t2_q[csr_rd_idx];
`ifdef LSU_TRIG_HITCNT_EN
      2'd2:    csr_rd_data = {16'b0, cnt_q[csr_rd_idx]};
`endif
      default: csr_rd_data = '0;
    endcase
  end

  // Packets: load is suppressed by address/data select, nothing fires in debug mode
  always_comb begin
    trigger_pkt_any = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      trigger_pkt_any[i].select = t1_q[i][SELECT];
      trigger_pkt_any[i].match  = t1_q[i][MATCH];
      trigger_pkt_any[i].store  = t1_q[i][STORE] & t1_q[i][MBIT] & ~dbg_mode;
      trigger_pkt_any[i].load   = t1_q[i][LOAD] & ~t1_q[i][SELECT] & t1_q[i][MBIT] & ~dbg_mode;
      trigger_pkt_any[i].tdata2 = t2_q[i];
    end
  end

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Bench for lsu_trigger_ctl: directed table, corner sequences, and random traffic against a reference model.
module tb_lsu_trigger_ctl;
  import lsu_trigger_ctl_pkg::*;

  logic               clk = 1'b0;
  logic               rst, dbg_mode, csr_wr_valid, csr_wr_ready, csr_wr_reg;
  logic [1:0]         csr_wr_idx, csr_rd_idx, csr_rd_reg;
  logic [31:0]        csr_wr_data, csr_rd_data;
  trigger_pkt_t [3:0] trigger_pkt_any;
  logic [3:0]         lsu_trigger_match_dc3, trig_req_vec;
  logic               lsu_kill_dc3, trig_req_valid, trig_req_action, trig_req_ack;

  int errors = 0;
  int checks = 0;

  lsu_trigger_ctl dut (
    .clk(clk), .rst(rst), .dbg_mode(dbg_mode),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready), .csr_wr_idx(csr_wr_idx),
    .csr_wr_reg(csr_wr_reg), .csr_wr_data(csr_wr_data),
    .csr_rd_idx(csr_rd_idx), .csr_rd_reg(csr_rd_reg), .csr_rd_data(csr_rd_data),
    .trigger_pkt_any(trigger_pkt_any),
    .lsu_trigger_match_dc3(lsu_trigger_match_dc3), .lsu_kill_dc3(lsu_kill_dc3),
    .trig_req_valid(trig_req_valid), .trig_req_action(trig_req_action),
    .trig_req_vec(trig_req_vec), .trig_req_ack(trig_req_ack)
  );

  always #5 clk = ~clk;

  // Reference model: architectural readback values and request bookkeeping
  logic [31:0] m_rb [4];
  logic [31:0] m_t2 [4];
  logic [15:0] m_cnt [4];
  logic [3:0]  m_dc4, m_vec;
  logic        m_busy, m_act;

  function automatic logic [31:0] fmask(input int i);
    return (i % 2 == 1) ? 32'h0818_10C3 : 32'h0818_18C3;
  endfunction

  task automatic model_clk();
    logic [3:0]  f;
    logic [3:0]  wrote;
    logic [31:0] nv;
    logic        act;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_rb[i] = 32'h2000_0000; m_t2[i] = 32'h0; m_cnt[i] = 16'h0;
      end
      m_dc4 = 4'h0; m_vec = 4'h0; m_busy = 1'b0; m_act = 1'b0;
    end else begin
      for (int p = 0; p < 4; p += 2) begin
        if (m_rb[p][11]) f[p+:2] = (m_dc4[p] && m_dc4[p+1]) ? 2'b11 : 2'b00;
        else             f[p+:2] = m_dc4[p+:2];
      end
      act = 1'b0;
      for (int i = 0; i < 4; i++) if (f[i] && m_rb[i][12]) act = 1'b1;
      wrote = 4'h0;
      if (csr_wr_valid && !m_busy && !(m_rb[csr_wr_idx][27] && !dbg_mode)) begin
        if (!csr_wr_reg) begin
          nv = 32'h2000_0000 | (csr_wr_data & fmask(int'(csr_wr_idx)));
          if (!dbg_mode) nv[27] = 1'b0;
          m_rb[csr_wr_idx]  = nv;
          m_cnt[csr_wr_idx] = 16'h0;
          wrote[csr_wr_idx] = 1'b1;
        end else begin
          m_t2[csr_wr_idx] = csr_wr_data;
        end
      end
      if (!m_busy && f != 4'h0) begin
        m_busy = 1'b1; m_vec = f; m_act = act;
        for (int i = 0; i < 4; i++) begin
          if (f[i] && !wrote[i]) begin
            m_rb[i][20] = 1'b1;
            if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
          end
        end
      end else if (m_busy && trig_req_ack) begin
        m_busy = 1'b0; m_vec = 4'h0; m_act = 1'b0;
      end
      m_dc4 = lsu_kill_dc3 ? 4'h0 : lsu_trigger_match_dc3;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic compare_model();
    logic [31:0]  erd;
    trigger_pkt_t ep;
    case (csr_rd_reg)
      2'd0: erd = m_rb[csr_rd_idx];
      2'd1: erd = m_t2[csr_rd_idx];
`ifdef LSU_TRIG_HITCNT_EN
      2'd2: erd = {16'h0, m_cnt[csr_rd_idx]};
`endif
      default: erd = 32'h0;
    endcase
    chk("ready", 64'(csr_wr_ready), 64'(!m_busy));
    chk("valid", 64'(trig_req_valid), 64'(m_busy));
    chk("vec", 64'(trig_req_vec), 64'(m_vec));
    chk("action", 64'(trig_req_action), 64'(m_act));
    chk("rd_data", 64'(csr_rd_data), 64'(erd));
    for (int i = 0; i < 4; i++) begin
      ep.select = m_rb[i][19];
      ep.match  = m_rb[i][7];
      ep.store  = m_rb[i][1] & m_rb[i][6] & !dbg_mode;
      ep.load   = m_rb[i][0] & !m_rb[i][19] & m_rb[i][6] & !dbg_mode;
      ep.tdata2 = m_t2[i];
      chk($sformatf("pkt%0d", i), 64'(trigger_pkt_any[i]), 64'(ep));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_clk();
    compare_model();
  endtask

  task automatic clr_in();
    csr_wr_valid = 1'b0; csr_wr_idx = 2'd0; csr_wr_reg = 1'b0; csr_wr_data = 32'h0;
    lsu_trigger_match_dc3 = 4'h0; lsu_kill_dc3 = 1'b0; trig_req_ack = 1'b0;
  endtask

  task automatic wr_csr(input logic [1:0] idx, input logic r, input logic [31:0] d);
    csr_wr_valid = 1'b1; csr_wr_idx = idx; csr_wr_reg = r; csr_wr_data = d;
    tick();
    csr_wr_valid = 1'b0;
  endtask

  task automatic fire_ack(input logic [3:0] m);
    lsu_trigger_match_dc3 = m; tick();
    lsu_trigger_match_dc3 = 4'h0; tick();
    trig_req_ack = 1'b1; tick();
    trig_req_ack = 1'b0;
  endtask

  typedef struct {
    logic        wv;
    logic [1:0]  widx;
    logic        wreg;
    logic [31:0] wdata;
    logic [3:0]  match;
    logic        ack;
    logic [1:0]  rdreg;
    logic        ev;
    logic [3:0]  evec;
    logic        eact;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 2'd0, 1'b0, 32'h42,   4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 32'h2000_0042};
    tbl[1] = '{1'b1, 2'd0, 1'b1, 32'h1000, 4'h0, 1'b0, 2'd1, 1'b0, 4'h0, 1'b0, 32'h1000};
    tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h0,    4'h1, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 32'h2000_0042};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 32'h0,    4'h0, 1'b0, 2'd0, 1'b1, 4'h1, 1'b0, 32'h2010_0042};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h0,    4'h0, 1'b0, 2'd0, 1'b1, 4'h1, 1'b0, 32'h2010_0042};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 32'h0,    4'h0, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 32'h2010_0042};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 32'h0,    4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 32'h2010_0042};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 32'h42,   4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 32'h2000_0042};

    clr_in();
    rst = 1'b1; dbg_mode = 1'b0; csr_rd_idx = 2'd0; csr_rd_reg = 2'd0;
    tick(); tick();
    chk("reset_valid", 64'(trig_req_valid), 64'h0);
    chk("reset_ready", 64'(csr_wr_ready), 64'h1);
    chk("reset_vec", 64'(trig_req_vec), 64'h0);
    chk("reset_tdata1", 64'(csr_rd_data), 64'h2000_0000);
    rst = 1'b0;

    // Store trigger on slot 0
    for (int r = 0; r < 8; r++) begin
      csr_wr_valid = tbl[r].wv; csr_wr_idx = tbl[r].widx; csr_wr_reg = tbl[r].wreg;
      csr_wr_data = tbl[r].wdata; lsu_trigger_match_dc3 = tbl[r].match;
      trig_req_ack = tbl[r].ack; csr_rd_idx = 2'd0; csr_rd_reg = tbl[r].rdreg;
      tick();
      chk($sformatf("tbl%0d_valid", r), 64'(trig_req_valid), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_vec", r), 64'(trig_req_vec), 64'(tbl[r].evec));
      chk($sformatf("tbl%0d_action", r), 64'(trig_req_action), 64'(tbl[r].eact));
      chk($sformatf("tbl%0d_rd", r), 64'(csr_rd_data), 64'(tbl[r].erd));
      clr_in();
    end
    csr_rd_reg = 2'd0;

    // Chain pair 2/3
    wr_csr(2'd2, 1'b0, 32'h842);
    wr_csr(2'd3, 1'b0, 32'h42);
    lsu_trigger_match_dc3 = 4'b0100; tick();
    lsu_trigger_match_dc3 = 4'h0; tick(); tick();
    chk("chain_single_valid", 64'(trig_req_valid), 64'h0);
    lsu_trigger_match_dc3 = 4'b1100; tick();
    lsu_trigger_match_dc3 = 4'h0; tick();
    chk("chain_pair_vec", 64'(trig_req_vec), 64'hC);
    trig_req_ack = 1'b1; tick(); trig_req_ack = 1'b0;

    // Killed match leaves no trace
    wr_csr(2'd1, 1'b0, 32'h42);
    csr_rd_idx = 2'd1;
    lsu_trigger_match_dc3 = 4'b0010; lsu_kill_dc3 = 1'b1; tick();
    clr_in(); tick(); tick();
    chk("kill_valid", 64'(trig_req_valid), 64'h0);
    chk("kill_hit1", 64'(csr_rd_data), 64'h2000_0042);

    // Busy: slot 1 match during REQ is dropped
    lsu_trigger_match_dc3 = 4'b0001; tick();
    lsu_trigger_match_dc3 = 4'h0; tick();
    chk("busy_ready", 64'(csr_wr_ready), 64'h0);
    lsu_trigger_match_dc3 = 4'b0010; tick();
    lsu_trigger_match_dc3 = 4'h0; tick(); tick();
    trig_req_ack = 1'b1; tick(); trig_req_ack = 1'b0; tick();
    chk("busy_hit1", 64'(csr_rd_data), 64'h2000_0042);

    // Mixed action: debug entry wins
    wr_csr(2'd1, 1'b0, 32'h1042);
    lsu_trigger_match_dc3 = 4'b0011; tick();
    lsu_trigger_match_dc3 = 4'h0; tick();
    chk("mixed_vec", 64'(trig_req_vec), 64'h3);
    chk("mixed_action", 64'(trig_req_action), 64'h1);
    trig_req_ack = 1'b1; tick(); trig_req_ack = 1'b0;

    // dmode lock
    csr_rd_idx = 2'd0;
    dbg_mode = 1'b1;
    wr_csr(2'd0, 1'b0, 32'h0800_0042);
    chk("dmode_set", 64'(csr_rd_data), 64'h2800_0042);
    chk("dbg_store_off", 64'(trigger_pkt_any[0].store), 64'h0);
    dbg_mode = 1'b0;
    wr_csr(2'd0, 1'b0, 32'h0);
    chk("dmode_locked", 64'(csr_rd_data), 64'h2800_0042);
    chk("nodbg_store_on", 64'(trigger_pkt_any[0].store), 64'h1);
    csr_rd_idx = 2'd1;
    wr_csr(2'd1, 1'b0, 32'h0800_0000);
    chk("dmode_needs_dbg", 64'(csr_rd_data), 64'h2000_0000);
    dbg_mode = 1'b1;
    wr_csr(2'd0, 1'b0, 32'h42);
    dbg_mode = 1'b0;

    // Hit counter
    csr_rd_idx = 2'd0;
    fire_ack(4'b0001); fire_ack(4'b0001); fire_ack(4'b0001);
    csr_rd_reg = 2'd2; tick();
`ifdef LSU_TRIG_HITCNT_EN
    chk("hitcnt3", 64'(csr_rd_data), 64'h3);
`else
    chk("hitcnt_absent", 64'(csr_rd_data), 64'h0);
`endif
    wr_csr(2'd0, 1'b0, 32'h42);
    chk("hitcnt_clr", 64'(csr_rd_data), 64'h0);
    csr_rd_reg = 2'd0;

    // Reset in the middle of a request
    lsu_trigger_match_dc3 = 4'b0001; tick();
    lsu_trigger_match_dc3 = 4'h0; tick();
    rst = 1'b1; tick();
    chk("rst_req_valid", 64'(trig_req_valid), 64'h0);
    chk("rst_req_ready", 64'(csr_wr_ready), 64'h1);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst                   = ($urandom % 400) == 0;
      dbg_mode              = ($urandom % 8) == 0;
      csr_wr_valid          = ($urandom % 3) == 0;
      csr_wr_idx            = 2'($urandom);
      csr_wr_reg            = 1'($urandom);
      csr_wr_data           = $urandom | (($urandom % 2) ? 32'h40 : 32'h0);
      csr_rd_idx            = 2'($urandom);
      csr_rd_reg            = 2'($urandom);
      lsu_trigger_match_dc3 = 4'($urandom);
      lsu_kill_dc3          = ($urandom % 4) == 0;
      trig_req_ack          = ($urandom % 3) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
